bus_sequencer: RTL and testbench

Upstream control stage for the Argon unit bus. It accepts queued transfer requests (source unit and command, destination unit and command) over a valid/ready handshake, buffers them in a small FIFO, and drives the switch's `write_id`, `read_id`, `write_command` and `read_command` inputs one transfer at a time. It completes each transfer when the master bus reports valid data, and optionally aborts a transfer that stalls past a timeout.

---
 rtl/constants_pkg.sv | 36 +++
 rtl/bus_req_fifo.sv | 58 +++++
 rtl/bus_sequencer.sv | 168 ++++++++++++++++
 tb/tb_bus_sequencer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/constants_pkg.sv
// Shared types and constants for the Argon bus sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Optional feature macro: BUS_SEQ_TIMEOUT_EN adds the ERROR state.
package constants_pkg;

    // ID_NONE must land in the switch's default branch so nothing is routed.
    localparam logic [3:0] ID_NONE = 4'hF;
    localparam logic [3:0] CMD_NOP = 4'h0;

    typedef struct packed {
        logic [3:0] src_id;
        logic [3:0] src_cmd;
        logic [3:0] dst_id;
        logic [3:0] dst_cmd;
    } bus_xfer_t;

    // Value driven onto the switch controls whenever no transfer is in flight.
    localparam bus_xfer_t IDLE_XFER = '{
        src_id:  ID_NONE,
        src_cmd: CMD_NOP,
        dst_id:  ID_NONE,
        dst_cmd: CMD_NOP
    };

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1
`ifdef BUS_SEQ_TIMEOUT_EN
        ,
        S_ERROR  = 2'd2
`endif
    } bus_seq_state_t;

endpackage

// File: rtl/bus_req_fifo.sv
// Request FIFO of bus_xfer_t entries; head is visible combinationally.
// Latency: a push is visible at the head one cycle later; no fall-through.
// Backpressure: caller must not push when full nor pop when empty.
//
// Ports: clk/rst (async active-high), push/push_data, pop/head,
//        full, empty, count (occupancy, one bit wider than the pointers).
module bus_req_fifo
    import constants_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  bus_xfer_t              push_data,
    input  logic                   pop,
    output bus_xfer_t              head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    bus_xfer_t      mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;

    // Storage carries no reset; only entries below count are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/bus_sequencer.sv
// Issues queued unit-bus transfers to the switch one at a time.
// Latency: enqueue into an empty FIFO at edge N drives the switch after edge N+1.
// Backpressure: o_req_ready drops when the FIFO is full (or in reset); no pass-through.
//
// Ports: i_Clk, i_Reset (async active-high); request handshake i_req_valid/o_req_ready
//        with i_req_{src,dst}_{id,cmd}; switch controls o_write_id/o_write_command/
//        o_read_id/o_read_command; i_bus_valid completes a transfer; status o_busy,
//        o_done (one-cycle pulse), o_error (sticky) and i_clear_error.
// Optional feature macro: BUS_SEQ_TIMEOUT_EN (stall timeout, ERROR state, o_error).
module bus_sequencer
    import constants_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_req_valid,
    output logic       o_req_ready,
    input  logic [3:0] i_req_src_id,
    input  logic [3:0] i_req_src_cmd,
    input  logic [3:0] i_req_dst_id,
    input  logic [3:0] i_req_dst_cmd,
    output logic [3:0] o_write_id,
    output logic [3:0] o_write_command,
    output logic [3:0] o_read_id,
    output logic [3:0] o_read_command,
    input  logic       i_bus_valid,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_error,
    input  logic       i_clear_error
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    bus_seq_state_t state;
    bus_seq_state_t state_nxt;
    bus_xfer_t      req;
    bus_xfer_t      head;
    bus_xfer_t      xfer_q;
    logic           push;
    logic           pop;
    logic           full;
    logic           empty;
    logic           done_nxt;
    logic [CW-1:0]  count;
    logic [CW-1:0]  count_nxt;

    assign req = '{
        src_id:  i_req_src_id,
        src_cmd: i_req_src_cmd,
        dst_id:  i_req_dst_id,
        dst_cmd: i_req_dst_cmd
    };

    // Ready looks only at the registered count, so a pop never frees a slot
    // in the same cycle.
    assign o_req_ready = !full && !i_Reset;
    assign push        = i_req_valid && o_req_ready;
    assign count_nxt   = count + CW'(push) - CW'(pop);

    bus_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (i_Clk),
        .rst       (i_Reset),
        .push      (push),
        .push_data (req),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

`ifdef BUS_SEQ_TIMEOUT_EN
    localparam int             TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]  TMO_LIMIT = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] tmo_cnt;

    // Counts stalled ACTIVE edges; saturates at the limit instead of wrapping.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            tmo_cnt <= '0;
        end else if (pop) begin
            tmo_cnt <= '0;
        end else if (state == S_ACTIVE && !i_bus_valid && tmo_cnt != TMO_LIMIT) begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            o_error <= 1'b0;
        end else if (state == S_ACTIVE && state_nxt == S_ERROR) begin
            o_error <= 1'b1;
        end else if (state == S_ERROR && i_clear_error) begin
            o_error <= 1'b0;
        end
    end
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    logic unused_clear;
    assign unused_clear = i_clear_error;
    assign o_error      = 1'b0;
`endif

    // Leaving ACTIVE always passes through IDLE, which gives the mandatory
    // one-cycle ID_NONE/CMD_NOP gap between transfers.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (i_bus_valid) begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end
`ifdef BUS_SEQ_TIMEOUT_EN
                else if (tmo_cnt == TMO_LIMIT) begin
                    state_nxt = S_ERROR;
                end
`endif
            end
`ifdef BUS_SEQ_TIMEOUT_EN
            S_ERROR: begin
                if (i_clear_error) begin
                    state_nxt = S_IDLE;
                end
            end
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state  <= S_IDLE;
            xfer_q <= IDLE_XFER;
            o_done <= 1'b0;
            o_busy <= 1'b0;
        end else begin
            state  <= state_nxt;
            o_done <= done_nxt;
            o_busy <= (state_nxt != S_IDLE) || (count_nxt != '0);
            if (pop) begin
                xfer_q <= head;
            end else if (state_nxt != S_ACTIVE) begin
                xfer_q <= IDLE_XFER;
            end
        end
    end

    assign o_write_id      = xfer_q.src_id;
    assign o_write_command = xfer_q.src_cmd;
    assign o_read_id       = xfer_q.dst_id;
    assign o_read_command  = xfer_q.dst_cmd;

endmodule

// File: tb/tb_bus_sequencer.sv
// Self-checking bench for bus_sequencer: directed vector table, corner-case
// sequences, and randomized traffic against a queue-based transfer model.
// Honours BUS_SEQ_TIMEOUT_EN to select the timeout or the wait-forever test.
module tb_bus_sequencer;
    import constants_pkg::*;

    localparam int         DEPTH      = 4;
    localparam int         TMO        = 16;
    localparam logic [3:0] ID_ALU     = 4'h1;
    localparam logic [3:0] ID_REGFILE = 4'h2;

    logic       i_Clk = 1'b0;
    logic       i_Reset = 1'b0;
    logic       i_req_valid = 1'b0;
    logic       o_req_ready;
    logic [3:0] i_req_src_id = '0;
    logic [3:0] i_req_src_cmd = '0;
    logic [3:0] i_req_dst_id = '0;
    logic [3:0] i_req_dst_cmd = '0;
    logic [3:0] o_write_id;
    logic [3:0] o_write_command;
    logic [3:0] o_read_id;
    logic [3:0] o_read_command;
    logic       i_bus_valid = 1'b0;
    logic       o_busy;
    logic       o_done;
    logic       o_error;
    logic       i_clear_error = 1'b0;

    int checks   = 0;
    int failures = 0;

    always #5 i_Clk = ~i_Clk;

    bus_sequencer #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .i_Clk           (i_Clk),
        .i_Reset         (i_Reset),
        .i_req_valid     (i_req_valid),
        .o_req_ready     (o_req_ready),
        .i_req_src_id    (i_req_src_id),
        .i_req_src_cmd   (i_req_src_cmd),
        .i_req_dst_id    (i_req_dst_id),
        .i_req_dst_cmd   (i_req_dst_cmd),
        .o_write_id      (o_write_id),
        .o_write_command (o_write_command),
        .o_read_id       (o_read_id),
        .o_read_command  (o_read_command),
        .i_bus_valid     (i_bus_valid),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_error         (o_error),
        .i_clear_error   (i_clear_error)
    );

    // ---------------- reference model: a queue plus "transfer in flight" ----
    bus_xfer_t m_q[$];
    bus_xfer_t m_cur;
    bit        m_act;
    bit        m_done;
    bit        m_err;
    int        m_age;

    task automatic model_reset();
        m_q.delete();
        m_cur  = IDLE_XFER;
        m_act  = 1'b0;
        m_done = 1'b0;
        m_err  = 1'b0;
        m_age  = 0;
    endtask

    // One clock edge of the transfer rules.
    task automatic model_step(input bit vld, input bus_xfer_t r, input bit bv, input bit clr);
        bit acc;
        acc    = vld && (m_q.size() < DEPTH);
        m_done = 1'b0;
        if (m_err) begin
            if (clr) m_err = 1'b0;
        end else if (m_act) begin
            if (bv) begin
                m_act  = 1'b0;
                m_done = 1'b1;
            end
`ifdef BUS_SEQ_TIMEOUT_EN
            else if (m_age == TMO) begin
                m_act = 1'b0;
                m_err = 1'b1;
            end
`endif
            else begin
                m_age++;
            end
        end else if (m_q.size() > 0) begin
            m_cur = m_q.pop_front();
            m_act = 1'b1;
            m_age = 0;
        end
        if (acc) m_q.push_back(r);
    endtask

    function automatic logic [18:0] model_vec();
        bus_xfer_t x;
        x = m_act ? m_cur : IDLE_XFER;
        return {x, m_done, (m_act || m_err || m_q.size() != 0), m_err};
    endfunction

    function automatic logic [18:0] dut_vec();
        return {o_write_id, o_write_command, o_read_id, o_read_command, o_done, o_busy, o_error};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs (called just after a falling edge), advance
    // through the rising edge and compare against the model at the next fall.
    task automatic cycle(input bit vld, input bus_xfer_t r, input bit bv, input bit clr);
        i_req_valid   = vld;
        i_req_src_id  = r.src_id;
        i_req_src_cmd = r.src_cmd;
        i_req_dst_id  = r.dst_id;
        i_req_dst_cmd = r.dst_cmd;
        i_bus_valid   = bv;
        i_clear_error = clr;
        #1;
        chk("ready", 32'(o_req_ready), 32'(m_q.size() < DEPTH));
        model_step(vld, r, bv, clr);
        @(posedge i_Clk);
        @(negedge i_Clk);
        chk("model", 32'(dut_vec()), 32'(model_vec()));
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit        vld;
        bus_xfer_t req;
        bit        bv;
        bus_xfer_t exp_x;
        bit        exp_done;
        bit        exp_busy;
    } vec_t;

    localparam bus_xfer_t XA = '{src_id: ID_ALU, src_cmd: 4'd3, dst_id: ID_REGFILE, dst_cmd: 4'd2};
    localparam bus_xfer_t XB = '{src_id: 4'h3, src_cmd: 4'h5, dst_id: 4'h4, dst_cmd: 4'h6};
    localparam bus_xfer_t XC = '{src_id: 4'h7, src_cmd: 4'h1, dst_id: 4'h7, dst_cmd: 4'h9};
    localparam bus_xfer_t XI = IDLE_XFER;

    vec_t vt[14];

    initial begin
        int n;
        int done_cnt;
        int issued;
        bit seen_done;

        // Single transfer: bus valid on the 3rd ACTIVE cycle.
        vt[0]  = '{1'b1, XA, 1'b0, XI, 1'b0, 1'b1};
        vt[1]  = '{1'b0, XA, 1'b0, XA, 1'b0, 1'b1};
        vt[2]  = '{1'b0, XA, 1'b0, XA, 1'b0, 1'b1};
        vt[3]  = '{1'b0, XA, 1'b0, XA, 1'b0, 1'b1};
        vt[4]  = '{1'b0, XA, 1'b1, XI, 1'b1, 1'b0};
        vt[5]  = '{1'b0, XA, 1'b0, XI, 1'b0, 1'b0};
        // Back-to-back with bus valid tied high; XC has src == dst.
        vt[6]  = '{1'b1, XA, 1'b1, XI, 1'b0, 1'b1};
        vt[7]  = '{1'b1, XB, 1'b1, XA, 1'b0, 1'b1};
        vt[8]  = '{1'b1, XC, 1'b1, XI, 1'b1, 1'b1};
        vt[9]  = '{1'b0, XC, 1'b1, XB, 1'b0, 1'b1};
        vt[10] = '{1'b0, XC, 1'b1, XI, 1'b1, 1'b1};
        vt[11] = '{1'b0, XC, 1'b1, XC, 1'b0, 1'b1};
        vt[12] = '{1'b0, XC, 1'b1, XI, 1'b1, 1'b0};
        vt[13] = '{1'b0, XC, 1'b1, XI, 1'b0, 1'b0};

        // ---------------- reset ----------------
        model_reset();
        #1 i_Reset = 1'b1;
        #1;
        chk("rst_ready_low", 32'(o_req_ready), 32'd0);
        chk("rst_outputs", 32'(dut_vec()), 32'({XI, 3'b000}));
        repeat (2) @(negedge i_Clk);
        i_Reset = 1'b0;
        #1;
        chk("rst_ready_high", 32'(o_req_ready), 32'd1);
        chk("rst_outputs_rel", 32'(dut_vec()), 32'({XI, 3'b000}));

        for (int i = 0; i < 14; i++) begin
            cycle(vt[i].vld, vt[i].req, vt[i].bv, 1'b0);
            chk($sformatf("vec%0d", i),
                32'({o_write_id, o_write_command, o_read_id, o_read_command, o_done, o_busy}),
                32'({vt[i].exp_x, vt[i].exp_done, vt[i].exp_busy}));
        end

        // ---------------- full FIFO while a transfer stalls ----------------
        cycle(1'b1, XA, 1'b0, 1'b0);
        cycle(1'b0, XA, 1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            cycle(1'b1, '{src_id: 4'(k), src_cmd: 4'(k + 8), dst_id: 4'(k + 4), dst_cmd: 4'(k)}, 1'b0, 1'b0);
        end
        chk("full_ready", 32'(o_req_ready), 32'd0);
        repeat (2) cycle(1'b1, XB, 1'b0, 1'b0);
        cycle(1'b1, XB, 1'b1, 1'b0);          // XA completes, FIFO still full
        chk("no_passthru_ready", 32'(o_req_ready), 32'd0);
        cycle(1'b1, XB, 1'b0, 1'b0);          // first pop happens on this edge
        chk("ready_after_pop", 32'(o_req_ready), 32'd1);
        cycle(1'b1, XB, 1'b0, 1'b0);          // held 5th request now accepted
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, XB, 1'b1, 1'b0);
            if (o_done) done_cnt++;
        end
        chk("full_drain_done", 32'(done_cnt), 32'd5);

        // ---------------- reset mid-ACTIVE ----------------
        cycle(1'b1, XA, 1'b0, 1'b0);
        cycle(1'b1, XB, 1'b0, 1'b0);
        cycle(1'b1, XC, 1'b0, 1'b0);
        chk("pre_rst_active", 32'(o_write_id), 32'(XA.src_id));
        #2 i_Reset = 1'b1;
        #1;
        chk("arst_outputs", 32'(dut_vec()), 32'({XI, 3'b000}));
        chk("arst_ready", 32'(o_req_ready), 32'd0);
        model_reset();
        repeat (2) @(negedge i_Clk);
        i_Reset = 1'b0;
        issued = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, XA, 1'b1, 1'b0);
            if (o_write_id != ID_NONE) issued++;
        end
        chk("post_rst_no_issue", 32'(issued), 32'd0);
        cycle(1'b1, XB, 1'b0, 1'b0);
        cycle(1'b0, XB, 1'b0, 1'b0);
        chk("post_rst_new_issue", 32'(o_write_id), 32'(XB.src_id));
        cycle(1'b0, XB, 1'b1, 1'b0);
        cycle(1'b0, XB, 1'b0, 1'b0);

`ifdef BUS_SEQ_TIMEOUT_EN
        // ---------------- timeout ----------------
        cycle(1'b1, XA, 1'b0, 1'b0);
        cycle(1'b1, XB, 1'b0, 1'b0);
        n = 0;
        seen_done = 1'b0;
        for (int i = 0; i < 64 && !o_error; i++) begin
            if (o_write_id == XA.src_id) n++;
            if (o_done) seen_done = 1'b1;
            cycle(1'b0, XA, 1'b0, 1'b0);
        end
        chk("tmo_active_cycles", 32'(n), 32'(TMO + 1));
        chk("tmo_error", 32'(o_error), 32'd1);
        chk("tmo_no_done", 32'({seen_done, o_done}), 32'd0);
        repeat (2) cycle(1'b0, XA, 1'b0, 1'b0);
        chk("err_sticky", 32'(o_error), 32'd1);
        cycle(1'b0, XA, 1'b0, 1'b1);
        chk("err_cleared", 32'(o_error), 32'd0);
        cycle(1'b0, XA, 1'b0, 1'b0);
        chk("after_clear_issue", 32'(o_write_id), 32'(XB.src_id));
        cycle(1'b0, XA, 1'b1, 1'b0);
        cycle(1'b0, XA, 1'b0, 1'b0);
`else
        // ---------------- no timeout: waits indefinitely ----------------
        cycle(1'b1, XC, 1'b0, 1'b0);
        cycle(1'b0, XC, 1'b0, 1'b0);
        seen_done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            cycle(1'b0, XC, 1'b0, 1'b1);
            if (o_done) seen_done = 1'b1;
        end
        chk("wait_still_active", 32'(o_write_id), 32'(XC.src_id));
        chk("wait_no_error", 32'({seen_done, o_error}), 32'd0);
        cycle(1'b0, XC, 1'b1, 1'b0);
        chk("wait_done", 32'(o_done), 32'd1);
        cycle(1'b0, XC, 1'b0, 1'b0);
        n = 0;
`endif

        // ---------------- randomized traffic ----------------
        for (int i = 0; i < 600; i++) begin
            bus_xfer_t r;
            bit        v;
            bit        bv;
            bit        clr;
            r   = bus_xfer_t'(16'($urandom));
            v   = ($urandom_range(0, 9) < 6);
            bv  = ($urandom_range(0, 9) < 3) || (m_act && m_age >= 8);
            clr = ($urandom_range(0, 7) == 0);
            cycle(v, r, bv, clr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
